// File: rtl/sent_rx_pkg.sv
// Shared definitions for the SENT receive dispatcher: FSM encoding, source
// channel indices and default datapath parameters.
package sent_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ENABLE,
      ST_WAIT,
      ST_OUTPUT
   } state_t;

   localparam int SRC_FAST6    = 0;
   localparam int SRC_FAST4    = 1;
   localparam int SRC_FAST3    = 2;
   localparam int SRC_SHORT    = 3;
   localparam int SRC_ENHANCED = 4;

   localparam int DEF_DATA_W  = 24;
   localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/sent_rx_edge_arb.sv
// Falling-edge request capture per source, pending bookkeeping with overrun
// accounting, and lowest-index-first grant selection.
module sent_rx_edge_arb #(
   parameter int NUM_SRC = 5,
   parameter int IDX_W   = 3
) (
   input  logic               clk_rx,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] i_done,
   input  logic               i_take,
   output logic               o_any,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_overrun,
   output logic [7:0]         o_overrun_cnt
);

   logic [NUM_SRC-1:0] r_prev;
   logic [NUM_SRC-1:0] r_pending;
   logic               r_overrun;
   logic [7:0]         r_ovr_cnt;

   logic [NUM_SRC-1:0] w_fall;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_ovr;
   logic [IDX_W-1:0]   w_idx;

   always_comb begin
      w_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (r_pending[i]) w_idx = IDX_W'(i);
      end
   end

   // A bit being granted this cycle that sees a new edge keeps the request
   // and is not an overrun: the old request is already on its way out.
   assign w_fall = r_prev & ~i_done;
   assign w_clr  = i_take ? (NUM_SRC'(1) << w_idx) : '0;
   assign w_ovr  = w_fall & r_pending & ~w_clr;

   always_ff @(posedge clk_rx or negedge reset_n) begin
      if (!reset_n) begin
         r_prev    <= '0;
         r_pending <= '0;
         r_overrun <= 1'b0;
         r_ovr_cnt <= '0;
      end else begin
         r_prev    <= i_done;
         r_pending <= (r_pending & ~w_clr) | w_fall;
         if (|w_ovr) begin
            r_overrun <= 1'b1;
            if (r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
         end
      end
   end

   assign o_any         = |r_pending;
   assign o_idx         = w_idx;
   assign o_overrun     = r_overrun;
   assign o_overrun_cnt = r_ovr_cnt;

endmodule

// File: rtl/sent_rx_dispatch.sv
// Serialises CRC checks for several SENT frame sources: one request at a time
// is enabled toward the checker, and its result is presented as one frame.
module sent_rx_dispatch
   import sent_rx_pkg::*;
#(
   parameter int NUM_SRC = 5,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                       clk_rx,
   input  logic                       reset_n,
   input  logic [NUM_SRC-1:0]         done_pre_data,
   output logic [NUM_SRC-1:0]         enable_crc_check,
   input  logic                       crc_done,
   input  logic                       crc_ok,
   input  logic [DATA_W-1:0]          crc_data,
   output logic                       frame_valid,
   output logic [DATA_W-1:0]          frame_data,
   output logic [$clog2(NUM_SRC)-1:0] frame_src,
   output logic                       frame_crc_err,
   output logic                       timeout_err,
   output logic                       overrun,
   output logic [7:0]                 overrun_cnt
);

   localparam int IDX_W = $clog2(NUM_SRC);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [TMO_W-1:0]   r_cnt;
   logic [DATA_W-1:0]  r_frame_data;
   logic [IDX_W-1:0]   r_frame_src;
   logic               r_frame_crc_err;

   logic               w_take;
   logic               w_any;
   logic [IDX_W-1:0]   w_grant_idx;
   logic               w_tmo_hit;

   sent_rx_edge_arb #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_edge_arb (
      .clk_rx        (clk_rx),
      .reset_n       (reset_n),
      .i_done        (done_pre_data),
      .i_take        (w_take),
      .o_any         (w_any),
      .o_idx         (w_grant_idx),
      .o_overrun     (overrun),
      .o_overrun_cnt (overrun_cnt)
   );

   assign w_tmo_hit = (r_cnt == TMO_W'(TIMEOUT));

   always_ff @(posedge clk_rx or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // A crc_done arriving in the final WAIT cycle still wins over the timeout.
   always_comb begin
      w_state_nxt      = r_state;
      w_take           = 1'b0;
      enable_crc_check = '0;
      frame_valid      = 1'b0;
      timeout_err      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_take      = 1'b1;
               w_state_nxt = ST_ENABLE;
            end
         end
         ST_ENABLE: begin
            enable_crc_check = NUM_SRC'(1) << r_idx;
            w_state_nxt      = ST_WAIT;
         end
         ST_WAIT: begin
            if (crc_done) begin
               w_state_nxt = ST_OUTPUT;
            end else if (w_tmo_hit) begin
               timeout_err = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_OUTPUT: begin
            frame_valid = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_rx or negedge reset_n) begin
      if (!reset_n) begin
         r_idx           <= '0;
         r_cnt           <= '0;
         r_frame_data    <= '0;
         r_frame_src     <= '0;
         r_frame_crc_err <= 1'b0;
      end else begin
         if (w_take) r_idx <= w_grant_idx;
         case (r_state)
            ST_ENABLE: r_cnt <= '0;
            ST_WAIT: begin
               if (crc_done) begin
                  r_frame_data    <= crc_data;
                  r_frame_src     <= r_idx;
                  r_frame_crc_err <= ~crc_ok;
               end else if (!w_tmo_hit) begin
                  r_cnt <= r_cnt + TMO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign frame_data    = r_frame_data;
   assign frame_src     = r_frame_src;
   assign frame_crc_err = r_frame_crc_err;

endmodule

// File: tb/tb_sent_rx_dispatch.sv
// Directed bench for sent_rx_dispatch: single and simultaneous requests,
// timeout, overrun saturation, CRC error and mid-transaction reset.
module tb_sent_rx_dispatch;

   logic        clk_rx = 1'b0;
   logic        reset_n;
   logic [4:0]  done_pre_data;
   logic [4:0]  enable_crc_check;
   logic        crc_done;
   logic        crc_ok;
   logic [23:0] crc_data;
   logic        frame_valid;
   logic [23:0] frame_data;
   logic [2:0]  frame_src;
   logic        frame_crc_err;
   logic        timeout_err;
   logic        overrun;
   logic [7:0]  overrun_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   sent_rx_dispatch dut (
      .clk_rx           (clk_rx),
      .reset_n          (reset_n),
      .done_pre_data    (done_pre_data),
      .enable_crc_check (enable_crc_check),
      .crc_done         (crc_done),
      .crc_ok           (crc_ok),
      .crc_data         (crc_data),
      .frame_valid      (frame_valid),
      .frame_data       (frame_data),
      .frame_src        (frame_src),
      .frame_crc_err    (frame_crc_err),
      .timeout_err      (timeout_err),
      .overrun          (overrun),
      .overrun_cnt      (overrun_cnt)
   );

   always #5 clk_rx = ~clk_rx;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_rx);
      #1;
   endtask

   // Low for one sampled edge, then high again for one edge.
   task automatic pulse_low(input logic [4:0] mask);
      done_pre_data = done_pre_data & ~mask;
      tick();
      done_pre_data = done_pre_data | mask;
      tick();
   endtask

   // Present a crc_done in the current WAIT cycle; returns in the OUTPUT cycle.
   task automatic crc_result(input logic [23:0] data, input logic ok);
      crc_done = 1'b1;
      crc_ok   = ok;
      crc_data = data;
      tick();
      crc_done = 1'b0;
      crc_ok   = 1'b0;
      crc_data = '0;
   endtask

   initial begin
      int  k;
      bit  seen;
      bit  fv;
      int  n_en;

      reset_n       = 1'b0;
      done_pre_data = 5'b01111;
      crc_done      = 1'b0;
      crc_ok        = 1'b0;
      crc_data      = '0;
      repeat (2) @(posedge clk_rx);
      #1;
      check("rst_enable", enable_crc_check, 0);
      check("rst_fvalid", frame_valid, 0);
      check("rst_fdata", frame_data, 0);
      check("rst_tmo", timeout_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_ovrcnt", overrun_cnt, 0);

      // Source 4 held low through reset must never request.
      reset_n = 1'b1;
      n_en = 0;
      repeat (4) begin
         tick();
         if (enable_crc_check != 0) n_en++;
      end
      check("lowheld_noreq", n_en, 0);
      done_pre_data = 5'b11111;
      repeat (2) tick();

      // Single request on source 0, result three cycles after enable.
      done_pre_data = 5'b11110;
      tick();
      done_pre_data = 5'b11111;
      check("s0_idle", enable_crc_check, 0);
      tick();
      check("s0_enable", enable_crc_check, 5'b00001);
      repeat (2) tick();
      crc_result(24'hABCDEF, 1'b1);
      check("s0_fvalid", frame_valid, 1);
      check("s0_fdata", frame_data, 24'hABCDEF);
      check("s0_fsrc", frame_src, 0);
      check("s0_crcerr", frame_crc_err, 0);
      tick();
      check("s0_fvalid_once", frame_valid, 0);
      check("s0_fdata_hold", frame_data, 24'hABCDEF);

      // Sources 1 and 3 fall together: 1 served first, then 3.
      pulse_low(5'b01010);
      check("dual_en1", enable_crc_check, 5'b00010);
      tick();
      crc_result(24'h111111, 1'b1);
      check("dual_fv1", frame_valid, 1);
      check("dual_src1", frame_src, 1);
      tick();
      check("dual_gap", enable_crc_check, 0);
      tick();
      check("dual_en3", enable_crc_check, 5'b01000);
      tick();
      crc_result(24'h333333, 1'b1);
      check("dual_fv3", frame_valid, 1);
      check("dual_src3", frame_src, 3);
      check("dual_data3", frame_data, 24'h333333);
      tick();

      // No crc_done: timeout strobe 256 cycles after the enable cycle.
      pulse_low(5'b00100);
      check("tmo_enable", enable_crc_check, 5'b00100);
      k = 0; seen = 0; fv = 0;
      while (!seen && k < 400) begin
         tick();
         k++;
         if (timeout_err) seen = 1;
         if (frame_valid) fv = 1;
      end
      check("tmo_cycles", k, 256);
      check("tmo_nofv", fv, 0);
      tick();
      check("tmo_once", timeout_err, 0);
      check("tmo_idle", enable_crc_check, 0);
      check("tmo_fv_after", frame_valid, 0);

      // Source 2 falls twice while queued behind source 0.
      pulse_low(5'b00001);
      check("ovr_en0", enable_crc_check, 5'b00001);
      pulse_low(5'b00100);
      check("ovr_first", overrun, 0);
      pulse_low(5'b00100);
      check("ovr_flag", overrun, 1);
      check("ovr_cnt1", overrun_cnt, 1);
      crc_result(24'h0C0C0C, 1'b1);
      check("ovr_fv0", frame_valid, 1);
      check("ovr_src0", frame_src, 0);
      tick();
      tick();
      check("ovr_en2", enable_crc_check, 5'b00100);
      tick();
      crc_result(24'h222222, 1'b1);
      check("ovr_src2", frame_src, 2);
      check("ovr_data2", frame_data, 24'h222222);
      n_en = 0;
      repeat (6) begin
         tick();
         if (enable_crc_check != 0 || frame_valid) n_en++;
      end
      check("ovr_single_service", n_en, 0);

      // CRC failure; source in service re-requests without overrun.
      pulse_low(5'b00010);
      check("bad_en1", enable_crc_check, 5'b00010);
      pulse_low(5'b00010);
      check("insvc_no_ovr", overrun_cnt, 1);
      crc_result(24'h5A5A5A, 1'b0);
      check("bad_fv", frame_valid, 1);
      check("bad_crcerr", frame_crc_err, 1);
      check("bad_src", frame_src, 1);
      tick();
      tick();
      check("insvc_reen", enable_crc_check, 5'b00010);
      tick();
      crc_result(24'h777777, 1'b1);
      check("insvc_fv", frame_valid, 1);
      check("insvc_crcerr", frame_crc_err, 0);
      tick();

      // Reset asserted during WAIT; a late crc_done must be ignored.
      pulse_low(5'b01000);
      check("rw_enable", enable_crc_check, 5'b01000);
      tick();
      reset_n = 1'b0;
      #1;
      check("rw_fdata", frame_data, 0);
      check("rw_fvalid", frame_valid, 0);
      check("rw_ovr", overrun, 0);
      check("rw_ovrcnt", overrun_cnt, 0);
      check("rw_enable0", enable_crc_check, 0);
      tick();
      reset_n = 1'b1;
      tick();
      crc_result(24'h999999, 1'b1);
      fv = frame_valid; seen = timeout_err;
      repeat (300) begin
         tick();
         if (frame_valid) fv = 1;
         if (timeout_err) seen = 1;
      end
      check("rw_late_fv", fv, 0);
      check("rw_no_tmo", seen, 0);
      check("rw_fdata_kept0", frame_data, 0);

      // Flood source 4 while busy: overrun counter saturates at 255.
      pulse_low(5'b00001);
      repeat (400) pulse_low(5'b10000);
      check("sat_flag", overrun, 1);
      check("sat_cnt", overrun_cnt, 255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
